// File: rtl/capsense_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : capsense_scanner
//  Purpose  : Multi-channel capacitive touch scanner. One shared charge pin
//             charges every pad, is released, and a single shared counter
//             times each pad's discharge. Per-channel threshold/hysteresis
//             turns the counts into debounced touch flags; the raw counts
//             are readable through a select mux.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock
//    reset      in   synchronous, active-high reset
//    enable     in   level; while high, scans repeat back-to-back
//    threshold  in   touch threshold in count units
//    hysteresis in   release margin below threshold
//    sense_in   in   raw pad inputs (asynchronous, synchronised here)
//    charge_out out  drives the shared charge pin
//    touched    out  debounced touch flags
//    scan_done  out  one-cycle pulse when a scan's results commit
//    busy       out  high whenever the scanner is not idle
//    rd_sel     in   channel select for rd_count
//    rd_count   out  last committed count of channel rd_sel (0 if out of range)
// ============================================================================
module capsense_scanner #(
   parameter int NUM_SENSE     = 4,
   parameter int CNT_WIDTH     = 16,
   parameter int CHARGE_CYCLES = 64,
   parameter int TIMEOUT       = 4095,
   parameter int SEL_WIDTH     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] threshold,
   input  logic [CNT_WIDTH-1:0] hysteresis,
   input  logic [NUM_SENSE-1:0] sense_in,
   output logic                 charge_out,
   output logic [NUM_SENSE-1:0] touched,
   output logic                 scan_done,
   output logic                 busy,
   input  logic [SEL_WIDTH-1:0] rd_sel,
   output logic [CNT_WIDTH-1:0] rd_count
);

   localparam logic [CNT_WIDTH-1:0] C_TIMEOUT     = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] C_CHARGE_LAST = CNT_WIDTH'(CHARGE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] C_ONE         = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CHARGE    = 2'd1,
      ST_DISCHARGE = 2'd2,
      ST_UPDATE    = 2'd3
   } state_t;

   state_t                 state_q,   state_d;
   logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
   logic [NUM_SENSE-1:0]   sync1_q,   sync1_d;
   logic [NUM_SENSE-1:0]   sync2_q,   sync2_d;
   logic [NUM_SENSE-1:0]   latched_q, latched_d;
   logic [NUM_SENSE-1:0]   touched_q, touched_d;
   logic [CNT_WIDTH-1:0]   count_tmp_q [NUM_SENSE];
   logic [CNT_WIDTH-1:0]   count_tmp_d [NUM_SENSE];
   logic [CNT_WIDTH-1:0]   counts_q    [NUM_SENSE];
   logic [CNT_WIDTH-1:0]   counts_d    [NUM_SENSE];

   // Channels that discharge below the input threshold in this cycle and
   // have not been timed yet; the exit test includes same-cycle latches.
   logic [NUM_SENSE-1:0]   w_latch_now;
   logic [NUM_SENSE-1:0]   w_latched_all;
   logic                   w_all_done;
   logic [CNT_WIDTH-1:0]   w_release;

   assign w_latch_now   = ~latched_q & ~sync2_q;
   assign w_latched_all = latched_q | w_latch_now;
   assign w_all_done    = &w_latched_all;

   // Release level saturates at zero so a large hysteresis never wraps.
   assign w_release = (hysteresis > threshold) ? '0 : (threshold - hysteresis);

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sync1_d     = sense_in;
      sync2_d     = sync1_q;
      latched_d   = latched_q;
      touched_d   = touched_q;
      count_tmp_d = count_tmp_q;
      counts_d    = counts_q;
      charge_out  = 1'b0;
      scan_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_CHARGE;
               cnt_d   = '0;
            end
         end

         ST_CHARGE: begin
            charge_out = 1'b1;
            if (cnt_q == C_CHARGE_LAST) begin
               state_d   = ST_DISCHARGE;
               cnt_d     = '0;
               latched_d = '0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end

         ST_DISCHARGE: begin
            for (int i = 0; i < NUM_SENSE; i++) begin
               if (w_latch_now[i]) begin
                  count_tmp_d[i] = cnt_q;
               end
            end
            latched_d = w_latched_all;
            if (w_all_done || (cnt_q == C_TIMEOUT)) begin
               state_d = ST_UPDATE;
               // Pads that never discharged report the timeout value.
               for (int i = 0; i < NUM_SENSE; i++) begin
                  if (!w_latched_all[i]) begin
                     count_tmp_d[i] = C_TIMEOUT;
                  end
               end
               latched_d = '1;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end

         ST_UPDATE: begin
            scan_done = 1'b1;
            state_d   = ST_IDLE;
            for (int i = 0; i < NUM_SENSE; i++) begin
               counts_d[i] = count_tmp_q[i];
               if (count_tmp_q[i] > threshold) begin
                  touched_d[i] = 1'b1;
               end else if (count_tmp_q[i] < w_release) begin
                  touched_d[i] = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         latched_q <= '0;
         touched_q <= '0;
         for (int i = 0; i < NUM_SENSE; i++) begin
            count_tmp_q[i] <= '0;
            counts_q[i]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         latched_q <= latched_d;
         touched_q <= touched_d;
         for (int i = 0; i < NUM_SENSE; i++) begin
            count_tmp_q[i] <= count_tmp_d[i];
            counts_q[i]    <= counts_d[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs and read mux (stored counts only change in UPDATE)
   // -------------------------------------------------------------------------
   assign touched = touched_q;
   assign busy    = (state_q != ST_IDLE);

   always_comb begin
      rd_count = '0;
      for (int i = 0; i < NUM_SENSE; i++) begin
         if (rd_sel == SEL_WIDTH'(i)) begin
            rd_count = counts_q[i];
         end
      end
   end

endmodule
`default_nettype wire
